result_pack_writer: RTL and testbench
=====================================

Name: result_pack_writer

Overview:
- Downstream stage of the calculator datapath.
- Accepts a stream of DATA_W-bit results from the arithmetic unit over a valid/ready handshake.
- Packs each pair of results into one MEM_WORD_SIZE-bit word and writes it to the 512-line result SRAM.
- Writes start at a programmed base address and advance one line per packed word, until the programmed end address has been written.

Parameters:
- DATA_W, 32, width of one result.
- MEM_WORD_SIZE, 64, SRAM word width; must equal 2*DATA_W.
- ADDR_W, 9, SRAM address width (512 lines).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_i  input  1  one-cycle pulse; latch base/end addresses and begin; honoured only in IDLE or DONE.
- base_addr_i  input  ADDR_W  first SRAM line to write.
- end_addr_i  input  ADDR_W  last SRAM line to write (inclusive).
- res_valid_i  input  1  result valid.
- res_data_i  input  DATA_W  result value.
- res_ready_o  output  1  block can accept a result this cycle.
- flush_i  input  1  force out a half-filled word and finish.
- wr_en_o  output  1  SRAM write strobe, one cycle per word.
- wr_addr_o  output  ADDR_W  SRAM write address.
- wr_data_o  output  MEM_WORD_SIZE  SRAM write data.
- busy_o  output  1  high in FILL_LO, FILL_HI, WRITE.
- done_o  output  1  high in DONE until next start_i.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - res_ready_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, done_o=0.
  - Internal address, end address and pack register all cleared.
- Reset mid-operation: any partial word is discarded and no write is issued. After reset, the block waits for a new start_i.
- All outputs are registered.
- FSM states: IDLE, FILL_LO, FILL_HI, WRITE, DONE.
- IDLE / DONE:
  - start_i loads addr<=base_addr_i, end<=end_addr_i and clears the pack register.
  - Next state FILL_LO; done_o drops the same edge.
  - start_i in any other state is ignored.
- FILL_LO:
  - res_ready_o=1.
  - On accept (valid&&ready): pack[31:0]<=res_data_i, go FILL_HI.
  - flush_i with no accept: go DONE, no write.
  - flush_i with accept on the same cycle: go FILL_HI with a pending flush flag set.
- FILL_HI:
  - res_ready_o=1.
  - On accept: pack[63:32]<=res_data_i, go WRITE.
  - flush_i (or a pending flush) with no accept: pack[63:32]<=0, go WRITE, and finish after that write.
  - Accept and flush on the same cycle: the accept wins and the word is written full. The flush still terminates the run after that write.
- WRITE:
  - res_ready_o=0; wr_en_o=1 for exactly one cycle; wr_addr_o=addr; wr_data_o=pack.
  - If addr==end, or a flush is pending: go DONE.
  - Otherwise addr<=addr+1 modulo 2^ADDR_W, clear the pack register, go FILL_LO.
- Latency: the wr_en_o pulse is asserted on the cycle after the clock edge that accepts the high result.
- Sustained throughput: 2 results per 3 cycles.
- Wrap-around:
  - The address wraps 511->0.
  - If end < base, the run spans the wrap: (512-base+end+1) words.
  - If base==end, exactly one word is written.
- Flush/done flags: the pending-flush flag clears on entry to DONE. done_o=1 only in DONE.
- No back-pressure on the SRAM side; every write is assumed to complete in one cycle.

Test Plan:
- Basic pack and write:
  - Stimulus: reset, start base=0x010 end=0x011; stream 0x11111111, 0x22222222, 0x33333333, 0x44444444 with valid held high.
  - Required: two writes: addr 0x010 data 0x22222222_11111111, then addr 0x011 data 0x44444444_33333333.
  - Required: done_o=1 after the second write; res_ready_o=0 in each WRITE cycle.
- Wrap-around:
  - Stimulus: start base=0x1FF end=0x000; four results 1,2,3,4.
  - Required: writes at 0x1FF (0x00000002_00000001) then 0x000 (0x00000004_00000003), then done.
- Flush of a half word:
  - Stimulus: start base=0x020 end=0x02F; send 0xDEADBEEF, then pulse flush_i.
  - Required: one write addr 0x020 data 0x00000000_DEADBEEF, then done_o.
  - Stimulus: a second run with flush_i while in FILL_LO.
  - Required: DONE with no write.
- Simultaneous accept and flush:
  - Stimulus: in FILL_HI, drive valid=1 data=0xCAFEF00D and flush_i=1 on the same cycle.
  - Required: full word written with [63:32]=0xCAFEF00D, then done_o.
- Back-pressure and ignored start:
  - Stimulus: toggle res_valid_i randomly; pulse start_i while busy.
  - Required: words are formed only from accepted beats, in order; the mid-run start_i has no effect.
- Reset mid-run:
  - Stimulus: after 1 accepted result, drop rst_n asynchronously (between clock edges).
  - Required: all outputs 0 immediately, no write issued; a fresh start_i base=0x005 writes first at 0x005.

Source files
------------

// File: rtl/result_pack_writer.sv
// Packs pairs of arithmetic results into double-width words and writes them
// to consecutive lines of the result SRAM between a base and end address.
module result_pack_writer #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int ADDR_W        = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        base_addr_i,
  input  logic [ADDR_W-1:0]        end_addr_i,
  input  logic                     res_valid_i,
  input  logic [DATA_W-1:0]        res_data_i,
  output logic                     res_ready_o,
  input  logic                     flush_i,
  output logic                     wr_en_o,
  output logic [ADDR_W-1:0]        wr_addr_o,
  output logic [MEM_WORD_SIZE-1:0] wr_data_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [2:0] {
    IDLE,
    FILL_LO,
    FILL_HI,
    WRITE,
    DONE
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [ADDR_W-1:0]        addr;
  logic [ADDR_W-1:0]        addr_next;
  logic [ADDR_W-1:0]        end_addr;
  logic [ADDR_W-1:0]        end_next;
  logic [MEM_WORD_SIZE-1:0] pack;
  logic [MEM_WORD_SIZE-1:0] pack_next;
  logic                     pending;
  logic                     pending_next;
  logic                     accept;

  // res_ready_o is registered from the next state, so it is high exactly in
  // FILL_LO/FILL_HI and can be used directly as the handshake qualifier.
  assign accept = res_valid_i && res_ready_o;

  always_comb begin
    state_next   = state;
    addr_next    = addr;
    end_next     = end_addr;
    pack_next    = pack;
    pending_next = pending;
    case (state)
      IDLE, DONE: begin
        if (start_i) begin
          addr_next    = base_addr_i;
          end_next     = end_addr_i;
          pack_next    = '0;
          pending_next = 1'b0;
          state_next   = FILL_LO;
        end
      end
      FILL_LO: begin
        if (accept) begin
          pack_next[DATA_W-1:0] = res_data_i;
          state_next            = FILL_HI;
          if (flush_i) pending_next = 1'b1;
        end else if (flush_i) begin
          pending_next = 1'b0;
          state_next   = DONE;
        end
      end
      FILL_HI: begin
        // A result arriving together with a flush still completes the word.
        if (accept) begin
          pack_next[MEM_WORD_SIZE-1:DATA_W] = res_data_i;
          state_next                        = WRITE;
          if (flush_i) pending_next = 1'b1;
        end else if (flush_i || pending) begin
          pack_next[MEM_WORD_SIZE-1:DATA_W] = '0;
          pending_next                      = 1'b1;
          state_next                        = WRITE;
        end
      end
      WRITE: begin
        if (addr == end_addr || pending) begin
          pending_next = 1'b0;
          state_next   = DONE;
        end else begin
          addr_next  = addr + ADDR_W'(1);
          pack_next  = '0;
          state_next = FILL_LO;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe without any combinational path to the ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      end_addr    <= '0;
      pack        <= '0;
      pending     <= 1'b0;
      res_ready_o <= 1'b0;
      wr_en_o     <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state       <= state_next;
      addr        <= addr_next;
      end_addr    <= end_next;
      pack        <= pack_next;
      pending     <= pending_next;
      res_ready_o <= (state_next == FILL_LO) || (state_next == FILL_HI);
      wr_en_o     <= (state_next == WRITE);
      if (state_next == WRITE) begin
        wr_addr_o <= addr_next;
        wr_data_o <= pack_next;
      end
      busy_o <= (state_next == FILL_LO) || (state_next == FILL_HI) ||
                (state_next == WRITE);
      done_o <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_result_pack_writer.sv
// Directed and randomized bench for result_pack_writer; expected SRAM writes
// are derived from the accepted result stream and the address range.
module tb_result_pack_writer;

  localparam int DW = 32;
  localparam int MW = 64;
  localparam int AW = 9;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [AW-1:0] end_addr_i;
  logic          res_valid_i;
  logic [DW-1:0] res_data_i;
  logic          res_ready_o;
  logic          flush_i;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [MW-1:0] wr_data_o;
  logic          busy_o;
  logic          done_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [AW-1:0] obs_addr[$];
  logic [MW-1:0] obs_data[$];
  int            obs_cyc[$];
  logic [DW-1:0] sent[$];
  int            acc_cyc[$];

  result_pack_writer #(.DATA_W(DW), .MEM_WORD_SIZE(MW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .end_addr_i (end_addr_i),
    .res_valid_i(res_valid_i),
    .res_data_i (res_data_i),
    .res_ready_o(res_ready_o),
    .flush_i    (flush_i),
    .wr_en_o    (wr_en_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe is captured with the cycle it appeared in.
  always @(negedge clk) begin
    if (wr_en_o === 1'b1) begin
      obs_addr.push_back(wr_addr_o);
      obs_data.push_back(wr_data_o);
      obs_cyc.push_back(cyc);
      check("ready_low_in_write", MW'(res_ready_o), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [AW-1:0] b, input logic [AW-1:0] e);
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
    sent.delete();
    acc_cyc.delete();
    base_addr_i = b;
    end_addr_i  = e;
    start_i     = 1'b1;
    tick();
    start_i = 1'b0;
    check("busy_after_start", MW'(busy_o), 1);
    check("done_after_start", MW'(done_o), 0);
  endtask

  task automatic send_beat(input logic [DW-1:0] v, input bit rnd);
    int guard = 0;
    bit got   = 0;
    while (!got && guard < 100) begin
      res_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      res_data_i  = v;
      got         = res_valid_i && res_ready_o;
      tick();
      guard++;
    end
    res_valid_i = 1'b0;
    if (got) begin
      sent.push_back(v);
      acc_cyc.push_back(cyc);
    end else begin
      check("accept_timeout", 0, 1);
    end
  endtask

  function automatic int span_words(input int b, input int e);
    return (e >= b) ? (e - b + 1) : (512 - b + e + 1);
  endfunction

  // Expected words: accepted results taken in pairs (low first), a lone
  // trailing result padded with zero, at consecutive wrapping addresses.
  task automatic finish_run(input int b, input int words);
    int g = 0;
    int n;
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    while (done_o !== 1'b1 && g < 60) begin
      tick();
      g++;
    end
    check("done_reached", MW'(done_o), 1);
    check("busy_at_done", MW'(busy_o), 0);
    check("ready_at_done", MW'(res_ready_o), 0);
    check("write_count", MW'(obs_addr.size()), MW'(words));
    n = (obs_addr.size() < words) ? obs_addr.size() : words;
    for (int i = 0; i < n; i++) begin
      lo = (2 * i < sent.size()) ? sent[2 * i] : '0;
      hi = (2 * i + 1 < sent.size()) ? sent[2 * i + 1] : '0;
      check("write_addr", MW'(obs_addr[i]), MW'((b + i) % 512));
      check("write_data", obs_data[i], {hi, lo});
      if (2 * i + 1 < sent.size())
        check("write_latency", MW'(obs_cyc[i]), MW'(acc_cyc[2 * i + 1]));
    end
  endtask

  initial begin
    int b;
    int e;
    rst_n       = 1'b0;
    start_i     = 1'b0;
    base_addr_i = '0;
    end_addr_i  = '0;
    res_valid_i = 1'b0;
    res_data_i  = '0;
    flush_i     = 1'b0;
    #2;
    check("reset_ready", MW'(res_ready_o), 0);
    check("reset_wr_en", MW'(wr_en_o), 0);
    check("reset_wr_addr", MW'(wr_addr_o), 0);
    check("reset_wr_data", wr_data_o, 0);
    check("reset_busy", MW'(busy_o), 0);
    check("reset_done", MW'(done_o), 0);
    tick();
    tick();
    rst_n = 1'b1;
    res_valid_i = 1'b1;
    tick();
    tick();
    res_valid_i = 1'b0;
    check("idle_ready", MW'(res_ready_o), 0);
    check("idle_no_write", MW'(obs_addr.size()), 0);

    $display("[TB] basic pack and write");
    start_run(9'h010, 9'h011);
    send_beat(32'h11111111, 1'b0);
    send_beat(32'h22222222, 1'b0);
    send_beat(32'h33333333, 1'b0);
    send_beat(32'h44444444, 1'b0);
    finish_run(9'h010, 2);

    $display("[TB] wrap-around");
    start_run(9'h1FF, 9'h000);
    for (int i = 1; i <= 4; i++) send_beat(DW'(i), 1'b0);
    finish_run(9'h1FF, span_words(9'h1FF, 9'h000));

    $display("[TB] flush of a half word");
    start_run(9'h020, 9'h02F);
    send_beat(32'hDEADBEEF, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    finish_run(9'h020, 1);

    start_run(9'h030, 9'h03F);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    finish_run(9'h030, 0);

    $display("[TB] accept and flush together");
    start_run(9'h040, 9'h04F);
    send_beat(32'h12345678, 1'b0);
    res_valid_i = 1'b1;
    res_data_i  = 32'hCAFEF00D;
    flush_i     = 1'b1;
    tick();
    sent.push_back(32'hCAFEF00D);
    acc_cyc.push_back(cyc);
    res_valid_i = 1'b0;
    flush_i     = 1'b0;
    finish_run(9'h040, 1);

    start_run(9'h050, 9'h05F);
    res_valid_i = 1'b1;
    res_data_i  = 32'hA5A50001;
    flush_i     = 1'b1;
    tick();
    sent.push_back(32'hA5A50001);
    acc_cyc.push_back(cyc);
    res_valid_i = 1'b0;
    flush_i     = 1'b0;
    finish_run(9'h050, 1);

    $display("[TB] back-pressure and ignored start");
    start_run(9'h1F0, 9'h1F5);
    for (int i = 0; i < 12; i++) begin
      send_beat($urandom, 1'b1);
      if (i == 4 || i == 7) begin
        base_addr_i = 9'h100;
        end_addr_i  = 9'h100;
        start_i     = 1'b1;
        tick();
        start_i = 1'b0;
      end
    end
    finish_run(9'h1F0, span_words(9'h1F0, 9'h1F5));

    b = $urandom_range(500, 511);
    e = $urandom_range(0, 4);
    start_run(AW'(b), AW'(e));
    for (int i = 0; i < 2 * span_words(b, e); i++) send_beat($urandom, 1'b1);
    finish_run(b, span_words(b, e));

    $display("[TB] reset mid-run");
    start_run(9'h060, 9'h06F);
    send_beat(32'h77777777, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_ready", MW'(res_ready_o), 0);
    check("midreset_wr_en", MW'(wr_en_o), 0);
    check("midreset_wr_addr", MW'(wr_addr_o), 0);
    check("midreset_wr_data", wr_data_o, 0);
    check("midreset_busy", MW'(busy_o), 0);
    check("midreset_done", MW'(done_o), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("midreset_no_write", MW'(obs_addr.size()), 0);
    check("midreset_idle_ready", MW'(res_ready_o), 0);
    start_run(9'h005, 9'h005);
    send_beat(32'h0BADF00D, 1'b0);
    send_beat(32'h600DCAFE, 1'b0);
    finish_run(9'h005, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
